// File: rtl/alu32_pkg.sv
// Shared types for the round-robin add/sub ALU slice.
package alu32_pkg;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

    typedef logic [31:0] word_t;

    typedef struct packed {
        logic carry;
        logic overflow;
        logic zero;
    } flags_t;

endpackage

// File: rtl/alu32_addsub.sv
// Combinational 32-bit two's-complement add/sub with carry, overflow and zero flags.
module alu32_addsub
    import alu32_pkg::*;
(
    input  logic  subAdd,
    input  word_t a,
    input  word_t b,
    output word_t result,
    output logic  carry,
    output logic  overflow,
    output logic  zero
);

    word_t       bx;
    logic [32:0] sum;

    // Subtraction is a + ~b + 1, so carry=1 means no borrow.
    assign bx       = b ^ {32{subAdd}};
    assign sum      = {1'b0, a} + {1'b0, bx} + {32'b0, subAdd};
    assign result   = sum[31:0];
    assign carry    = sum[32];
    assign overflow = (a[31] == bx[31]) & (sum[31] != a[31]);
    assign zero     = ~|sum[31:0];

endmodule

// File: rtl/alu32_rr_scheduler.sv
// Round-robin arbiter sharing one add/sub ALU between NREQ requesters,
// with a single response register drained by a valid/ready consumer.
module alu32_rr_scheduler
    import alu32_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int IDW  = $clog2(NREQ)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NREQ-1:0]      req_valid,
    input  logic [NREQ-1:0]      req_sub_add,
    input  logic [32*NREQ-1:0]   req_a,
    input  logic [32*NREQ-1:0]   req_b,
    output logic [NREQ-1:0]      req_ready,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [IDW-1:0]       rsp_id,
    output logic [31:0]          rsp_result,
    output logic                 rsp_carry,
    output logic                 rsp_overflow,
    output logic                 rsp_zero
);

    localparam logic [0:0] ST_EMPTY = 1'b0;
    localparam logic [0:0] ST_FULL  = 1'b1;

    logic [0:0]     state;
    logic [IDW-1:0] ptr;
    logic [IDW-1:0] ptrNext;
    logic [IDW-1:0] scanIdx;
    logic           canAccept;

    logic           grantValid_p0;
    logic [IDW-1:0] grantIdx_p0;
    logic           xfer_p0;
    word_t          opA_p0;
    word_t          opB_p0;
    logic           opSub_p0;
    word_t          aluResult_p0;
    flags_t         aluFlags_p0;

    logic [IDW-1:0] id_p1;
    word_t          result_p1;
    flags_t         flags_p1;

    word_t          aWords [NREQ];
    word_t          bWords [NREQ];

    for (genvar i = 0; i < NREQ; i++) begin : gUnpack
        assign aWords[i] = req_a[32*i +: 32];
        assign bWords[i] = req_b[32*i +: 32];
    end

    assign canAccept = (state == ST_EMPTY) | rsp_ready;

    // Scan from ptr+NREQ-1 down to ptr so the last hit is the first valid at or after ptr.
    always_comb begin
        grantValid_p0 = 1'b0;
        grantIdx_p0   = '0;
        scanIdx       = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            scanIdx = IDW'((int'(ptr) + k) % NREQ);
            if (req_valid[scanIdx]) begin
                grantValid_p0 = 1'b1;
                grantIdx_p0   = scanIdx;
            end
        end
    end

    assign xfer_p0   = canAccept & grantValid_p0;
    assign req_ready = xfer_p0 ? (NREQ'(1) << grantIdx_p0) : '0;
    assign ptrNext   = (grantIdx_p0 == IDW'(NREQ - 1)) ? '0 : grantIdx_p0 + 1'b1;

    assign opA_p0   = aWords[grantIdx_p0];
    assign opB_p0   = bWords[grantIdx_p0];
    assign opSub_p0 = req_sub_add[grantIdx_p0];

    alu32_addsub uAlu (
        .subAdd   (opSub_p0),
        .a        (opA_p0),
        .b        (opB_p0),
        .result   (aluResult_p0),
        .carry    (aluFlags_p0.carry),
        .overflow (aluFlags_p0.overflow),
        .zero     (aluFlags_p0.zero)
    );

    // p0 -> p1: grant and ALU result captured into the response register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_EMPTY;
            ptr       <= '0;
            id_p1     <= '0;
            result_p1 <= '0;
            flags_p1  <= '0;
        end else if (xfer_p0) begin
            state     <= ST_FULL;
            ptr       <= ptrNext;
            id_p1     <= grantIdx_p0;
            result_p1 <= aluResult_p0;
            flags_p1  <= aluFlags_p0;
        end else if (state == ST_FULL && rsp_ready) begin
            state <= ST_EMPTY;
        end
    end

    assign rsp_valid    = (state == ST_FULL);
    assign rsp_id       = id_p1;
    assign rsp_result   = result_p1;
    assign rsp_carry    = flags_p1.carry;
    assign rsp_overflow = flags_p1.overflow;
    assign rsp_zero     = flags_p1.zero;

endmodule

// File: tb/tb_alu32_rr_scheduler.sv
// Self-checking bench for alu32_rr_scheduler: directed scenarios plus a
// randomized run against a transaction-level reference model.
module tb_alu32_rr_scheduler;

    localparam int NREQ = 4;
    localparam int IDW  = 2;

    logic                clk = 1'b0;
    logic                rst_n;
    logic [NREQ-1:0]     reqValid;
    logic [NREQ-1:0]     reqSubAdd;
    logic [32*NREQ-1:0]  reqA;
    logic [32*NREQ-1:0]  reqB;
    logic [NREQ-1:0]     reqReady;
    logic                rspValid;
    logic                rspReady;
    logic [IDW-1:0]      rspId;
    logic [31:0]         rspResult;
    logic                rspCarry;
    logic                rspOverflow;
    logic                rspZero;

    int nVec = 0;
    int nErr = 0;

    // Reference model state: transaction view of the scheduler.
    int          mPtr;
    bit          mFull;
    int          mId;
    logic [31:0] mRes;
    logic        mC, mV, mZ;

    alu32_rr_scheduler #(.NREQ(NREQ), .IDW(IDW)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req_valid    (reqValid),
        .req_sub_add  (reqSubAdd),
        .req_a        (reqA),
        .req_b        (reqB),
        .req_ready    (reqReady),
        .rsp_valid    (rspValid),
        .rsp_ready    (rspReady),
        .rsp_id       (rspId),
        .rsp_result   (rspResult),
        .rsp_carry    (rspCarry),
        .rsp_overflow (rspOverflow),
        .rsp_zero     (rspZero)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic void refAlu(input logic sub, input logic [31:0] a, input logic [31:0] b,
                                   output logic [31:0] r, output logic c, output logic v,
                                   output logic z);
        longint      sa = $signed(a);
        longint      sb = $signed(b);
        longint      t;
        logic [63:0] u;
        if (sub) begin
            r = a - b;
            c = (a >= b);
            t = sa - sb;
        end else begin
            u = {32'b0, a} + {32'b0, b};
            r = u[31:0];
            c = u[32];
            t = sa + sb;
        end
        v = (t > 64'sd2147483647) || (t < -(64'sd2147483648));
        z = (r == 32'd0);
    endfunction

    function automatic int modelGrant();
        if (mFull && !rspReady) return -1;
        for (int k = 0; k < NREQ; k++) begin
            int j = (mPtr + k) % NREQ;
            if (reqValid[j]) return j;
        end
        return -1;
    endfunction

    function automatic logic [NREQ-1:0] expReady();
        int g = modelGrant();
        return (g < 0) ? '0 : (NREQ'(1) << g);
    endfunction

    function automatic logic [31:0] pickOperand();
        case ($urandom_range(0, 5))
            0:       return 32'h0000_0000;
            1:       return 32'h7FFF_FFFF;
            2:       return 32'h8000_0000;
            3:       return 32'hFFFF_FFFF;
            default: return $urandom;
        endcase
    endfunction

    task automatic modelReset();
        mPtr = 0; mFull = 0; mId = 0; mRes = '0; mC = 0; mV = 0; mZ = 0;
    endtask

    // Advance one clock, updating the model from the inputs seen before the edge.
    task automatic step();
        int          g;
        logic [31:0] r;
        logic        c, v, z;
        g = modelGrant();
        if (g >= 0) refAlu(reqSubAdd[g], reqA[32*g +: 32], reqB[32*g +: 32], r, c, v, z);
        @(posedge clk);
        if (g >= 0) begin
            mRes = r; mC = c; mV = v; mZ = z; mId = g;
            mPtr = (g + 1) % NREQ;
            mFull = 1;
        end else if (mFull && rspReady) begin
            mFull = 0;
        end
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; reqValid = '0; reqSubAdd = '0; reqA = '0; reqB = '0; rspReady = 1'b0;
        modelReset();
        #12;
        nVec++;
        if ({rspValid, rspId, rspResult, rspCarry, rspOverflow, rspZero} !== '0) begin
            nErr++;
            $display("FAIL reset_outputs: got v=%b id=%0d res=%h flags=%b, want all zero",
                     rspValid, rspId, rspResult, {rspCarry, rspOverflow, rspZero});
        end
        nVec++;
        if (reqReady !== 4'b0000) begin
            nErr++; $display("FAIL reset_ready: got %b want 0000", reqReady);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_single();
        reqA[31:0] = 32'h7FFF_FFFF; reqB[31:0] = 32'h1; reqSubAdd[0] = 1'b0;
        reqValid = 4'b0001; rspReady = 1'b1;
        #1;
        nVec++;
        if (reqReady !== 4'b0001) begin
            nErr++; $display("FAIL single_ready: got %b want 0001", reqReady);
        end
        step();
        reqValid = '0;
        nVec++;
        if ({rspValid, rspId, rspResult, rspCarry, rspOverflow, rspZero} !==
            {1'b1, 2'd0, 32'h8000_0000, 3'b010}) begin
            nErr++;
            $display("FAIL single_rsp: got v=%b id=%0d res=%h cvz=%b, want v=1 id=0 res=80000000 cvz=010",
                     rspValid, rspId, rspResult, {rspCarry, rspOverflow, rspZero});
        end
        step();
        nVec++;
        if (rspValid !== 1'b0 || rspResult !== 32'h8000_0000) begin
            nErr++;
            $display("FAIL single_pop: got v=%b res=%h, want v=0 res=80000000", rspValid, rspResult);
        end
    endtask

    task automatic test_sub_equal();
        reqSubAdd[2] = 1'b1; reqA[64 +: 32] = 32'h1234_5678; reqB[64 +: 32] = 32'h1234_5678;
        reqValid = 4'b0100;
        #1;
        nVec++;
        if (reqReady !== 4'b0100) begin
            nErr++; $display("FAIL subeq_ready: got %b want 0100", reqReady);
        end
        step();
        reqValid = '0;
        nVec++;
        if ({rspValid, rspId, rspResult, rspCarry, rspOverflow, rspZero} !==
            {1'b1, 2'd2, 32'h0, 3'b101}) begin
            nErr++;
            $display("FAIL subeq_rsp: got v=%b id=%0d res=%h cvz=%b, want v=1 id=2 res=0 cvz=101",
                     rspValid, rspId, rspResult, {rspCarry, rspOverflow, rspZero});
        end
        step();
    endtask

    task automatic test_fairness();
        int start = mPtr;
        int idx;
        for (int i = 0; i < NREQ; i++) begin
            reqSubAdd[i] = 1'($urandom_range(0, 1));
            reqA[32*i +: 32] = pickOperand();
            reqB[32*i +: 32] = pickOperand();
        end
        reqValid = 4'hF; rspReady = 1'b1;
        for (int k = 0; k < 8; k++) begin
            idx = (start + k) % NREQ;
            #1;
            nVec++;
            if (reqReady !== (NREQ'(1) << idx)) begin
                nErr++; $display("FAIL fair_grant%0d: got %b want one-hot %0d", k, reqReady, idx);
            end
            step();
            nVec++;
            if ({rspValid, rspId, rspResult, rspCarry, rspOverflow, rspZero} !==
                {1'b1, IDW'(idx), mRes, mC, mV, mZ}) begin
                nErr++;
                $display("FAIL fair_rsp%0d: got v=%b id=%0d res=%h, want v=1 id=%0d res=%h",
                         k, rspValid, rspId, rspResult, idx, mRes);
            end
            reqSubAdd[idx] = 1'($urandom_range(0, 1));
            reqA[32*idx +: 32] = pickOperand();
            reqB[32*idx +: 32] = pickOperand();
        end
    endtask

    task automatic test_backpressure();
        logic [IDW+35:0] held;
        int              want;
        held = {1'b1, IDW'(mId), mRes, mC, mV, mZ};
        rspReady = 1'b0;
        for (int k = 0; k < 5; k++) begin
            #1;
            nVec++;
            if (reqReady !== 4'b0000) begin
                nErr++; $display("FAIL bp_ready%0d: got %b want 0000", k, reqReady);
            end
            step();
            nVec++;
            if ({rspValid, rspId, rspResult, rspCarry, rspOverflow, rspZero} !== held) begin
                nErr++; $display("FAIL bp_hold%0d: got %h want %h", k,
                                 {rspValid, rspId, rspResult, rspCarry, rspOverflow, rspZero}, held);
            end
        end
        want = mPtr;
        rspReady = 1'b1;
        #1;
        nVec++;
        if (reqReady !== (NREQ'(1) << want)) begin
            nErr++; $display("FAIL bp_release: got %b want one-hot %0d", reqReady, want);
        end
        step();
        nVec++;
        if (rspValid !== 1'b1 || rspId !== IDW'(want)) begin
            nErr++; $display("FAIL bp_next: got v=%b id=%0d want v=1 id=%0d", rspValid, rspId, want);
        end
    endtask

    task automatic test_wrap_skip();
        reqValid = '0; rspReady = 1'b1;
        step();
        reqValid = 4'b0100;
        step();
        reqValid = 4'b0010;
        #1;
        nVec++;
        if (reqReady !== 4'b0010) begin
            nErr++; $display("FAIL wrap_grant: got %b want 0010", reqReady);
        end
        step();
        nVec++;
        if (rspId !== 2'd1 || rspValid !== 1'b1) begin
            nErr++; $display("FAIL wrap_rsp: got v=%b id=%0d want v=1 id=1", rspValid, rspId);
        end
        reqValid = 4'hF;
        #1;
        nVec++;
        if (reqReady !== 4'b0100) begin
            nErr++; $display("FAIL wrap_ptr: got %b want 0100", reqReady);
        end
        step();
        reqValid = '0;
        step();
    endtask

    task automatic test_random();
        int lastG = -1;
        int g;
        for (int n = 0; n < 400; n++) begin
            for (int i = 0; i < NREQ; i++) begin
                if (!reqValid[i] || i == lastG) begin
                    reqValid[i]  = 1'($urandom_range(0, 1));
                    reqSubAdd[i] = 1'($urandom_range(0, 1));
                    reqA[32*i +: 32] = pickOperand();
                    reqB[32*i +: 32] = ($urandom_range(0, 7) == 0) ? reqA[32*i +: 32] : pickOperand();
                end
            end
            rspReady = ($urandom_range(0, 3) != 0);
            #1;
            nVec++;
            if (reqReady !== expReady()) begin
                nErr++; $display("FAIL rand_ready@%0d: got %b want %b", n, reqReady, expReady());
            end
            g = modelGrant();
            step();
            lastG = g;
            nVec++;
            if ({rspValid, rspId, rspResult, rspCarry, rspOverflow, rspZero} !==
                {mFull, IDW'(mId), mRes, mC, mV, mZ}) begin
                nErr++;
                $display("FAIL rand_rsp@%0d: got v=%b id=%0d res=%h cvz=%b, want v=%b id=%0d res=%h cvz=%b",
                         n, rspValid, rspId, rspResult, {rspCarry, rspOverflow, rspZero},
                         mFull, mId, mRes, {mC, mV, mZ});
            end
        end
    endtask

    task automatic test_async_reset();
        reqValid = 4'b0010; reqSubAdd[1] = 1'b0;
        reqA[32 +: 32] = 32'hDEAD_BEEF; reqB[32 +: 32] = 32'h1; rspReady = 1'b1;
        step();
        reqValid = '0; rspReady = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        nVec++;
        if (rspValid !== 1'b0 || rspResult !== 32'h0) begin
            nErr++; $display("FAIL areset_drop: got v=%b res=%h want v=0 res=0", rspValid, rspResult);
        end
        modelReset();
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        reqValid = 4'b1100; rspReady = 1'b1;
        #1;
        nVec++;
        if (reqReady !== 4'b0100) begin
            nErr++; $display("FAIL areset_first: got %b want 0100", reqReady);
        end
        step();
        nVec++;
        if (rspValid !== 1'b1 || rspId !== 2'd2) begin
            nErr++; $display("FAIL areset_rsp: got v=%b id=%0d want v=1 id=2", rspValid, rspId);
        end
        reqValid = '0;
        step();
    endtask

    initial begin
        test_reset();
        test_single();
        test_sub_equal();
        test_fairness();
        test_backpressure();
        test_wrap_skip();
        test_random();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", nVec, nErr);
        $finish;
    end

endmodule
